// File: rtl/dma_channel_arbiter_pkg.sv
// Shared definitions for the DMA channel arbiter slice.
// Holds the controller FSM state encoding, the transfer direction encoding
// and the default channel count / address width used by the interface and top.
package dma_pkg;

    localparam int DMA_NCH = 4;   // channels sharing the single engine
    localparam int DMA_AW  = 10;  // address and word-count width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_GRANT   = 3'd2,
        ST_XFER    = 3'd3,
        ST_RELEASE = 3'd4
    } dma_state_e;

    // 0: IO -> DRAM (IOR/MEMW), 1: DRAM -> IO (MEMR/IOW)
    typedef enum logic {
        DIR_IO2DRAM = 1'b0,
        DIR_DRAM2IO = 1'b1
    } dma_dir_e;

endpackage

// File: rtl/dma_channel_arbiter_if.sv
// Bus bundle between the DMA arbiter, the CPU hold handshake, the
// configuration port and the DMA engine.
//   slave  : arbiter side (requests/config/HLDA/eng_eop in; DACK/HRQ/eng_*/tc out)
//   master : environment side (the mirror image)
interface dma_channel_arbiter_if
    import dma_pkg::*;
#(
    parameter int NCH = DMA_NCH,
    parameter int AW  = DMA_AW
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] DREQ;
    logic [NCH-1:0] DACK;
    logic           HRQ;
    logic           HLDA;
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [AW-1:0]  cfg_dram;
    logic [AW-1:0]  cfg_io;
    logic [AW-1:0]  cfg_cnt;
    logic           cfg_dir;
    logic [NCH-1:0] cfg_mask;
    logic           eng_start;
    logic [AW-1:0]  eng_dram;
    logic [AW-1:0]  eng_io;
    logic [AW-1:0]  eng_cnt;
    logic           eng_dir;
    logic           eng_abort;
    logic           eng_eop;
    logic [NCH-1:0] tc;

    modport master (
        output DREQ, HLDA, cfg_we, cfg_ch, cfg_dram, cfg_io, cfg_cnt, cfg_dir,
               cfg_mask, eng_eop,
        input  DACK, HRQ, eng_start, eng_dram, eng_io, eng_cnt, eng_dir,
               eng_abort, tc
    );

    modport slave (
        input  DREQ, HLDA, cfg_we, cfg_ch, cfg_dram, cfg_io, cfg_cnt, cfg_dir,
               cfg_mask, eng_eop,
        output DACK, HRQ, eng_start, eng_dram, eng_io, eng_cnt, eng_dir,
               eng_abort, tc
    );

endinterface

// File: rtl/dma_channel_arbiter_rr_pick.sv
// Round-robin picker: returns the first set bit of elig_i at or after ptr_i,
// wrapping modulo NCH. Purely combinational.
//   elig_i  : eligible channel vector
//   ptr_i   : round-robin starting index
//   valid_o : at least one channel eligible
//   idx_o   : winning channel index
module rr_pick #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic [NCH-1:0] elig_i,
    input  logic [CW-1:0]  ptr_i,
    output logic           valid_o,
    output logic [CW-1:0]  idx_o
);

    // Scan from the farthest offset down to offset 0 so the closest eligible
    // channel to the pointer is the last (winning) assignment.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (elig_i[(int'(ptr_i) + k) % NCH]) begin
                valid_o = 1'b1;
                idx_o   = CW'((int'(ptr_i) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: round-robin grants one of NCH channels to a single
// DMA engine, runs the CPU HRQ/HLDA hold handshake, launches/aborts the
// engine and keeps sticky per-channel terminal-count flags.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : slave modport of dma_channel_arbiter_if (requests, config,
//                hold handshake, engine control, tc flags)
module dma_channel_arbiter
    import dma_pkg::*;
#(
    parameter int NCH = DMA_NCH,
    parameter int AW  = DMA_AW
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    dma_channel_arbiter_if.slave  bus
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    dma_state_e     state_q, state_d;
    logic [CW-1:0]  sel_q, sel_d;
    logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
    logic           hrq_q, hrq_d;
    logic [NCH-1:0] dack_q, dack_d;
    logic [NCH-1:0] tc_q, tc_d;
    logic           start_q, start_d;
    logic           abort_q, abort_d;
    logic           load_eng;

    logic [AW-1:0]  dram_q [NCH];
    logic [AW-1:0]  io_q   [NCH];
    logic [AW-1:0]  cnt_q  [NCH];
    dma_dir_e       dir_q  [NCH];

    logic [AW-1:0]  eng_dram_q, eng_io_q, eng_cnt_q;
    dma_dir_e       eng_dir_q;

    logic [NCH-1:0] elig;
    logic [NCH-1:0] cfg_hit;
    logic           cfg_ok;
    logic           pick_valid;
    logic [CW-1:0]  pick_idx;
    logic [NCH-1:0] sel_onehot;

    // The selected channel's registers are frozen for the whole grant cycle.
    assign cfg_ok     = bus.cfg_we && ((state_q == ST_IDLE) || (bus.cfg_ch != sel_q));
    assign sel_onehot = NCH'(1) << sel_q;

    genvar gi;
    for (gi = 0; gi < NCH; gi++) begin : g_ch
        assign cfg_hit[gi] = cfg_ok && (bus.cfg_ch == CW'(gi));
        assign elig[gi]    = bus.DREQ[gi] & ~bus.cfg_mask[gi] &
                             (cnt_q[gi] != '0) & ~tc_q[gi];
    end

    rr_pick #(.NCH(NCH), .CW(CW)) u_rr_pick (
        .elig_i  (elig),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NCH; i++) begin
                dram_q[i] <= '0;
                io_q[i]   <= '0;
                cnt_q[i]  <= '0;
                dir_q[i]  <= DIR_IO2DRAM;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_hit[i]) begin
                    dram_q[i] <= bus.cfg_dram;
                    io_q[i]   <= bus.cfg_io;
                    cnt_q[i]  <= bus.cfg_cnt;
                    dir_q[i]  <= dma_dir_e'(bus.cfg_dir);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        hrq_d    = hrq_q;
        dack_d   = dack_q;
        tc_d     = tc_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        load_eng = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_HOLD;
                    sel_d   = pick_idx;
                    hrq_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.HLDA) begin
                    state_d  = ST_GRANT;
                    dack_d   = sel_onehot;
                    start_d  = 1'b1;
                    load_eng = 1'b1;
                end
            end
            ST_GRANT, ST_XFER: begin
                if (!bus.HLDA) begin
                    // CPU reclaimed the bus: cancel without touching tc/rr_ptr.
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                    dack_d  = '0;
                    hrq_d   = 1'b0;
                end else if (state_q == ST_GRANT) begin
                    state_d = ST_XFER;
                end else if (bus.eng_eop) begin
                    state_d     = ST_RELEASE;
                    tc_d[sel_q] = 1'b1;
                    rr_ptr_d    = (sel_q == CW'(NCH - 1)) ? '0 : sel_q + CW'(1);
                    dack_d      = '0;
                    hrq_d       = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (!bus.HLDA) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cfg_ok) begin
            tc_d[bus.cfg_ch] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            hrq_q      <= 1'b0;
            dack_q     <= '0;
            tc_q       <= '0;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            eng_dram_q <= '0;
            eng_io_q   <= '0;
            eng_cnt_q  <= '0;
            eng_dir_q  <= DIR_IO2DRAM;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            hrq_q    <= hrq_d;
            dack_q   <= dack_d;
            tc_q     <= tc_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
            if (load_eng) begin
                eng_dram_q <= dram_q[sel_q];
                eng_io_q   <= io_q[sel_q];
                eng_cnt_q  <= cnt_q[sel_q];
                eng_dir_q  <= dir_q[sel_q];
            end
        end
    end

    assign bus.DACK      = dack_q;
    assign bus.HRQ       = hrq_q;
    assign bus.eng_start = start_q;
    assign bus.eng_abort = abort_q;
    assign bus.eng_dram  = eng_dram_q;
    assign bus.eng_io    = eng_io_q;
    assign bus.eng_cnt   = eng_cnt_q;
    assign bus.eng_dir   = eng_dir_q;
    assign bus.tc        = tc_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
module tb_dma_channel_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 10;

    typedef struct {
        int           ch;
        logic [AW-1:0] dram;
        logic [AW-1:0] io;
        logic [AW-1:0] cnt;
        logic          dir;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   checks;
    int   errors;
    int   abort_seen;
    int   grant_no;
    exp_t exp_q[$];
    exp_t mon_e;

    dma_channel_arbiter_if #(.NCH(NCH), .AW(AW)) bus();

    dma_channel_arbiter #(.NCH(NCH), .AW(AW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard consumer: each engine launch pops the next expected grant.
    always @(negedge CLK) begin
        if (bus.eng_abort === 1'b1) abort_seen++;
        if (RST_N === 1'b1 && bus.eng_start === 1'b1) begin
            grant_no++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected dack=%b dram=%h no grant required", bus.DACK, bus.eng_dram);
            end else begin
                logic [NCH-1:0] edack;
                mon_e = exp_q.pop_front();
                edack = 4'b0001 << mon_e.ch;
                $display("grant #%0d dack=%b dram=%h io=%h cnt=%0d dir=%b", grant_no,
                         bus.DACK, bus.eng_dram, bus.eng_io, bus.eng_cnt, bus.eng_dir);
                if ({bus.DACK, bus.eng_dram, bus.eng_io, bus.eng_cnt, bus.eng_dir} !==
                    {edack, mon_e.dram, mon_e.io, mon_e.cnt, mon_e.dir}) begin
                    errors++;
                    $display("FAIL grant_content got dack=%b dram=%h io=%h cnt=%h dir=%b required dack=%b dram=%h io=%h cnt=%h dir=%b",
                             bus.DACK, bus.eng_dram, bus.eng_io, bus.eng_cnt, bus.eng_dir,
                             edack, mon_e.dram, mon_e.io, mon_e.cnt, mon_e.dir);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_exp(input int ch, input logic [AW-1:0] dram, input logic [AW-1:0] io,
                            input logic [AW-1:0] cnt, input logic dir);
        exp_t e;
        e.ch = ch; e.dram = dram; e.io = io; e.cnt = cnt; e.dir = dir;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input int ch, input logic [AW-1:0] dram, input logic [AW-1:0] io,
                             input logic [AW-1:0] cnt, input logic dir);
        bus.cfg_we   = 1'b1;
        bus.cfg_ch   = 2'(ch);
        bus.cfg_dram = dram;
        bus.cfg_io   = io;
        bus.cfg_cnt  = cnt;
        bus.cfg_dir  = dir;
        tick(1);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic apply_reset();
        RST_N        = 1'b0;
        bus.DREQ     = '0;
        bus.HLDA     = 1'b0;
        bus.eng_eop  = 1'b0;
        bus.cfg_mask = '0;
        bus.cfg_we   = 1'b0;
        tick(2);
        RST_N = 1'b1;
        tick(1);
    endtask

    task automatic wait_hrq(input logic level, input string what);
        int n = 0;
        while (bus.HRQ !== level && n < 50) begin
            tick(1);
            n++;
        end
        checks++;
        if (bus.HRQ !== level) begin
            errors++;
            $display("FAIL %s_hrq_timeout HRQ=%b required %b", what, bus.HRQ, level);
        end
    endtask

    task automatic wait_start(input string what);
        int n = 0;
        while (bus.eng_start !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checks++;
        if (bus.eng_start !== 1'b1) begin
            errors++;
            $display("FAIL %s_start_timeout eng_start=%b required 1", what, bus.eng_start);
        end
    endtask

    task automatic do_transfer(input int hlda_delay, input int xfer_len, input string what);
        wait_hrq(1'b1, what);
        tick(hlda_delay);
        bus.HLDA = 1'b1;
        wait_start(what);
        tick(xfer_len);
        bus.eng_eop = 1'b1;
        tick(1);
        bus.eng_eop = 1'b0;
        wait_hrq(1'b0, what);
        bus.HLDA = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.HRQ, bus.DACK, bus.eng_start, bus.eng_abort, bus.tc, bus.eng_cnt, bus.eng_dram} !== '0) begin
            errors++;
            $display("FAIL reset_state got hrq=%b dack=%b start=%b abort=%b tc=%b cnt=%h dram=%h required all 0",
                     bus.HRQ, bus.DACK, bus.eng_start, bus.eng_abort, bus.tc, bus.eng_cnt, bus.eng_dram);
        end
        RST_N = 1'b1;
        tick(3);
        checks++;
        if (bus.HRQ !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_hrq got %b required 0", bus.HRQ);
        end
    endtask

    task automatic test_single();
        apply_reset();
        cfg_write(1, 10'h100, 10'h020, 10'd5, 1'b0);
        push_exp(1, 10'h100, 10'h020, 10'd5, 1'b0);
        bus.DREQ = 4'b0010;
        wait_hrq(1'b1, "single");
        bus.eng_eop = 1'b1;          // stray end-of-process while holding
        tick(1);
        bus.eng_eop = 1'b0;
        tick(1);
        bus.HLDA = 1'b1;
        wait_start("single");
        tick(1);
        checks++;
        if ({bus.eng_start, bus.DACK, bus.eng_dram, bus.eng_cnt} !== {1'b0, 4'b0010, 10'h100, 10'd5}) begin
            errors++;
            $display("FAIL single_xfer got start=%b dack=%b dram=%h cnt=%0d required start=0 dack=0010 dram=100 cnt=5",
                     bus.eng_start, bus.DACK, bus.eng_dram, bus.eng_cnt);
        end
        bus.eng_eop = 1'b1;
        tick(1);
        bus.eng_eop = 1'b0;
        checks++;
        if ({bus.tc, bus.HRQ, bus.DACK} !== {4'b0010, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL single_eop got tc=%b hrq=%b dack=%b required tc=0010 hrq=0 dack=0000",
                     bus.tc, bus.HRQ, bus.DACK);
        end
        bus.HLDA = 1'b0;
        tick(4);
        checks++;
        if (bus.HRQ !== 1'b0) begin
            errors++;
            $display("FAIL single_tc_blocks got hrq=%b required 0", bus.HRQ);
        end
        bus.DREQ = '0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NCH; i++) cfg_write(i, 10'(16 * i + 1), 10'(i + 8), 10'(i + 2), 1'(i));
        bus.DREQ = 4'b1111;
        push_exp(0, 10'h001, 10'h008, 10'd2, 1'b0);
        do_transfer(1, 2, "rr0");
        // ch0 eligible again, but the pointer now sits at ch1
        cfg_write(0, 10'h3A0, 10'h0F0, 10'd7, 1'b1);
        push_exp(1, 10'h011, 10'h009, 10'd3, 1'b1);
        do_transfer(0, 1, "rr1");
        push_exp(2, 10'h021, 10'h00A, 10'd4, 1'b0);
        do_transfer(2, 3, "rr2");
        push_exp(3, 10'h031, 10'h00B, 10'd5, 1'b1);
        do_transfer(1, 1, "rr3");
        push_exp(0, 10'h3A0, 10'h0F0, 10'd7, 1'b1);
        do_transfer(1, 2, "rr0b");
        checks++;
        if (bus.tc !== 4'b1111) begin
            errors++;
            $display("FAIL rr_tc got %b required 1111", bus.tc);
        end
        bus.DREQ = '0;
    endtask

    task automatic test_abort();
        int a0;
        apply_reset();
        cfg_write(2, 10'h2C0, 10'h044, 10'd6, 1'b1);
        push_exp(2, 10'h2C0, 10'h044, 10'd6, 1'b1);
        push_exp(2, 10'h2C0, 10'h044, 10'd6, 1'b1);
        bus.DREQ = 4'b0100;
        a0 = abort_seen;
        wait_hrq(1'b1, "abort");
        bus.HLDA = 1'b1;
        wait_start("abort");
        tick(2);
        bus.HLDA = 1'b0;
        tick(1);
        checks++;
        if ({bus.eng_abort, bus.DACK, bus.HRQ, bus.tc} !== {1'b1, 4'b0000, 1'b0, 4'b0000}) begin
            errors++;
            $display("FAIL abort_pulse got abort=%b dack=%b hrq=%b tc=%b required abort=1 dack=0000 hrq=0 tc=0000",
                     bus.eng_abort, bus.DACK, bus.HRQ, bus.tc);
        end
        tick(1);
        checks++;
        if (abort_seen - a0 !== 1) begin
            errors++;
            $display("FAIL abort_count got %0d required 1", abort_seen - a0);
        end
        do_transfer(1, 2, "regrant");
        checks++;
        if (bus.tc !== 4'b0100) begin
            errors++;
            $display("FAIL abort_regrant_tc got %b required 0100", bus.tc);
        end
        bus.DREQ = '0;
    endtask

    task automatic test_masked();
        int hi = 0;
        apply_reset();
        cfg_write(0, 10'h050, 10'h001, 10'd3, 1'b0);
        cfg_write(3, 10'h070, 10'h002, 10'd0, 1'b0);
        bus.cfg_mask = 4'b0001;
        bus.DREQ     = 4'b1001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus.HRQ === 1'b1) hi++;
        end
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL masked_no_hrq got %0d cycles of HRQ required 0", hi);
        end
        bus.cfg_mask = 4'b0000;
        push_exp(0, 10'h050, 10'h001, 10'd3, 1'b0);
        do_transfer(1, 1, "unmasked");
        checks++;
        if (bus.tc !== 4'b0001) begin
            errors++;
            $display("FAIL cnt0_tc got %b required 0001", bus.tc);
        end
        bus.DREQ = '0;
    endtask

    task automatic test_cfg_sel();
        apply_reset();
        cfg_write(1, 10'h0AA, 10'h011, 10'd9, 1'b1);
        cfg_write(2, 10'h0BB, 10'h022, 10'd4, 1'b0);
        push_exp(1, 10'h0AA, 10'h011, 10'd9, 1'b1);
        bus.DREQ = 4'b0010;
        wait_hrq(1'b1, "cfgsel");
        bus.HLDA = 1'b1;
        wait_start("cfgsel");
        cfg_write(1, 10'h1FF, 10'h1EE, 10'd7, 1'b0);
        cfg_write(2, 10'h0CC, 10'h033, 10'd6, 1'b1);
        bus.DREQ = 4'b0000;           // request drop during the transfer
        tick(1);
        checks++;
        if ({bus.eng_cnt, bus.eng_dram, bus.DACK} !== {10'd9, 10'h0AA, 4'b0010}) begin
            errors++;
            $display("FAIL cfgsel_hold got cnt=%0d dram=%h dack=%b required cnt=9 dram=0aa dack=0010",
                     bus.eng_cnt, bus.eng_dram, bus.DACK);
        end
        bus.eng_eop = 1'b1;
        tick(1);
        bus.eng_eop = 1'b0;
        checks++;
        if ({bus.tc, bus.HRQ} !== {4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL cfgsel_eop got tc=%b hrq=%b required tc=0010 hrq=0", bus.tc, bus.HRQ);
        end
        bus.HLDA = 1'b0;
        tick(1);
        push_exp(2, 10'h0CC, 10'h033, 10'd6, 1'b1);
        bus.DREQ = 4'b0110;
        do_transfer(1, 1, "cfgother");
        bus.DREQ = '0;
    endtask

    task automatic test_reset_mid_xfer();
        int a0;
        int hi = 0;
        apply_reset();
        cfg_write(3, 10'h123, 10'h045, 10'd2, 1'b0);
        push_exp(3, 10'h123, 10'h045, 10'd2, 1'b0);
        bus.DREQ = 4'b1000;
        do_transfer(1, 1, "pre");
        cfg_write(0, 10'h200, 10'h100, 10'd8, 1'b1);
        push_exp(0, 10'h200, 10'h100, 10'd8, 1'b1);
        bus.DREQ = 4'b0001;
        a0 = abort_seen;
        wait_hrq(1'b1, "rstx");
        bus.HLDA = 1'b1;
        wait_start("rstx");
        tick(2);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({bus.HRQ, bus.DACK, bus.tc, bus.eng_start, bus.eng_abort, bus.eng_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_async got hrq=%b dack=%b tc=%b start=%b abort=%b cnt=%h required all 0",
                     bus.HRQ, bus.DACK, bus.tc, bus.eng_start, bus.eng_abort, bus.eng_cnt);
        end
        bus.HLDA = 1'b0;
        tick(2);
        RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (bus.HRQ === 1'b1) hi++;
        end
        checks++;
        if (hi !== 0 || abort_seen - a0 !== 0) begin
            errors++;
            $display("FAIL rst_after got hrq_cycles=%0d aborts=%0d required 0 and 0", hi, abort_seen - a0);
        end
        bus.DREQ = '0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        abort_seen = 0;
        grant_no   = 0;
        RST_N        = 1'b0;
        bus.DREQ     = '0;
        bus.HLDA     = 1'b0;
        bus.eng_eop  = 1'b0;
        bus.cfg_mask = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = '0;
        bus.cfg_dram = '0;
        bus.cfg_io   = '0;
        bus.cfg_cnt  = '0;
        bus.cfg_dir  = 1'b0;
        tick(1);
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_masked();
        test_cfg_sel();
        test_reset_mid_xfer();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending grants required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
